// File: rtl/ma_wbuf.sv
// j22 memory-access unit: routes loads/stores/ifetches to the TCM banks or the AHB master port.
// AHB stores are posted through a small write buffer; AHB loads wait for it to drain.
module ma_wbuf #(
   parameter int NUM_TCM  = 2,
   parameter int TCM_AW   = 18,
   parameter int WB_DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic                           req_wr,
   input  logic                           req_ifetch,
   input  logic [1:0]                     req_size,
   input  logic [31:0]                    req_addr,
   input  logic [31:0]                    req_wdata,
   input  logic [NUM_TCM-1:0]             tcm_en,
   input  logic [NUM_TCM*(32-TCM_AW)-1:0] tcm_base,
   output logic                           rsp_valid,
   output logic                           rsp_err,
   output logic [31:0]                    rsp_data,
   output logic [NUM_TCM-1:0]             tcm_sel,
   output logic                           tcm_wr,
   output logic [3:0]                     tcm_be,
   output logic [TCM_AW-1:0]              tcm_a,
   output logic [31:0]                    tcm_d,
   input  logic [NUM_TCM*32-1:0]          tcm_q,
   output logic [31:0]                    HADDR,
   output logic [1:0]                     HTRANS,
   output logic                           HWRITE,
   output logic [2:0]                     HSIZE,
   output logic [3:0]                     HPROT,
   output logic [31:0]                    HWDATA,
   input  logic [31:0]                    HRDATA,
   input  logic                           HREADY,
   output logic                           wb_empty
);

   localparam int BW  = 32 - TCM_AW;
   localparam int PW  = $clog2(WB_DEPTH);
   localparam int CW  = PW + 1;
   localparam int BKW = (NUM_TCM > 1) ? $clog2(NUM_TCM) : 1;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   typedef enum logic [2:0] {S_IDLE, S_WADDR, S_WDATA, S_RADDR, S_RDATA} state_t;

   // Big-endian byte enables for the addressed lane(s)
   function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lo);
      logic [3:0] be;
      case (size)
         2'd0:    be = 4'b1000 >> lo;
         2'd1:    be = lo[1] ? 4'b0011 : 4'b1100;
         2'd2:    be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] d);
      logic [31:0] r;
      case (size)
         2'd0:    r = {4{d[7:0]}};
         2'd1:    r = {2{d[15:0]}};
         default: r = d;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] lane_load(input logic [1:0] size, input logic [1:0] lo,
                                             input logic [31:0] q);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (lo)
         2'd0:    b = q[31:24];
         2'd1:    b = q[23:16];
         2'd2:    b = q[15:8];
         default: b = q[7:0];
      endcase
      h = lo[1] ? q[15:0] : q[31:16];
      case (size)
         2'd0:    r = {{24{b[7]}}, b};
         2'd1:    r = {{16{h[15]}}, h};
         default: r = q;
      endcase
      return r;
   endfunction

   function automatic logic is_bad(input logic [1:0] size, input logic [1:0] lo);
      logic r;
      case (size)
         2'd0:    r = 1'b0;
         2'd1:    r = lo[0];
         2'd2:    r = (lo != 2'b00);
         default: r = 1'b1;
      endcase
      return r;
   endfunction

   state_t             state_r, state_nxt_s;
   logic [NUM_TCM-1:0] match_s;
   logic               hit_s, bad_s, ld_busy_s, wb_full_s, rdy_s;
   logic               acc_s, tcm_acc_s, push_s, ld_acc_s;
   logic [BKW-1:0]     bank_s, bank_r;
   logic [1:0]         htrans_s;
   logic               wb_pop_s, rd_done_s;

   logic [31:0]        wb_addr_r [WB_DEPTH];
   logic [1:0]         wb_size_r [WB_DEPTH];
   logic [31:0]        wb_data_r [WB_DEPTH];
   logic [PW-1:0]      wr_ptr_r, rd_ptr_r;
   logic [CW-1:0]      cnt_r;

   logic [31:0]        haddr_r, hwdata_r, rsp_data_r;
   logic               hwrite_r, rsp_valid_r, rsp_err_r, tcm_rd_r;
   logic [2:0]         hsize_r;
   logic [3:0]         hprot_r;
   logic [1:0]         ld_size_r, ld_lo_r;

   // Bank decode; lowest matching enabled bank wins
   always_comb begin
      bank_s = {BKW{1'b0}};
      for (int i = 0; i < NUM_TCM; i++) begin
         match_s[i] = tcm_en[i] && (req_addr[31:TCM_AW] == tcm_base[i*BW +: BW]);
      end
      for (int i = NUM_TCM - 1; i >= 0; i--) begin
         bank_s = match_s[i] ? BKW'(i) : bank_s;
      end
      hit_s = |match_s;
   end

   assign bad_s     = is_bad(req_size, req_addr[1:0]);
   assign ld_busy_s = (state_r == S_RADDR) || (state_r == S_RDATA);
   assign wb_full_s = (cnt_r == CW'(WB_DEPTH));

   // Request acceptance
   always_comb begin
      if (ld_busy_s) begin
         rdy_s = 1'b0;
      end else if (bad_s || hit_s) begin
         rdy_s = 1'b1;
      end else if (req_wr) begin
         rdy_s = !wb_full_s;
      end else begin
         rdy_s = (state_r == S_IDLE) && (cnt_r == {CW{1'b0}});
      end
   end

   assign req_ready = rdy_s;
   assign acc_s     = req_valid && rdy_s;
   assign tcm_acc_s = acc_s && !bad_s && hit_s;
   assign push_s    = acc_s && !bad_s && !hit_s && req_wr;
   assign ld_acc_s  = acc_s && !bad_s && !hit_s && !req_wr;

   // TCM command is combinational so the bank sees it in the acceptance cycle
   always_comb begin
      for (int i = 0; i < NUM_TCM; i++) begin
         tcm_sel[i] = tcm_acc_s && (bank_s == BKW'(i));
      end
   end

   assign tcm_wr = req_wr;
   assign tcm_be = lane_be(req_size, req_addr[1:0]);
   assign tcm_a  = req_addr[TCM_AW-1:0];
   assign tcm_d  = lane_data(req_size, req_wdata);

   // Write-buffer storage
   always_ff @(posedge clk) begin
      if (push_s) begin
         wb_addr_r[wr_ptr_r] <= req_addr;
         wb_size_r[wr_ptr_r] <= req_size;
         wb_data_r[wr_ptr_r] <= lane_data(req_size, req_wdata);
      end
   end

   // Write-buffer pointers; head stays valid until its data phase completes
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         cnt_r    <= {CW{1'b0}};
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1'b1);
         if (wb_pop_s) rd_ptr_r <= rd_ptr_r + PW'(1'b1);
         case ({push_s, wb_pop_s})
            2'b10:   cnt_r <= cnt_r + CW'(1'b1);
            2'b01:   cnt_r <= cnt_r - CW'(1'b1);
            default: cnt_r <= cnt_r;
         endcase
      end
   end

   // AHB FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_r <= S_IDLE;
      else     state_r <= state_nxt_s;
   end

   // AHB FSM next state; buffered writes take priority over the load
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (cnt_r != {CW{1'b0}}) state_nxt_s = S_WADDR;
            else if (ld_acc_s)       state_nxt_s = S_RADDR;
            else                     state_nxt_s = S_IDLE;
         end
         S_WADDR: state_nxt_s = HREADY ? S_WDATA : S_WADDR;
         S_WDATA: state_nxt_s = HREADY ? S_IDLE  : S_WDATA;
         S_RADDR: state_nxt_s = HREADY ? S_RDATA : S_RADDR;
         S_RDATA: state_nxt_s = HREADY ? S_IDLE  : S_RDATA;
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // AHB FSM output decode
   always_comb begin
      htrans_s  = HTRANS_IDLE;
      wb_pop_s  = 1'b0;
      rd_done_s = 1'b0;
      case (state_r)
         S_WADDR, S_RADDR: htrans_s  = HTRANS_NONSEQ;
         S_WDATA:          wb_pop_s  = HREADY;
         S_RDATA:          rd_done_s = HREADY;
         default:          htrans_s  = HTRANS_IDLE;
      endcase
   end

   // AHB address/control and write data, loaded when a transfer starts
   always_ff @(posedge clk) begin
      if (rst) begin
         haddr_r  <= 32'h0000_0000;
         hwrite_r <= 1'b0;
         hsize_r  <= 3'b000;
         hprot_r  <= 4'b0011;
         hwdata_r <= 32'h0000_0000;
      end else if ((state_r == S_IDLE) && (cnt_r != {CW{1'b0}})) begin
         haddr_r  <= wb_addr_r[rd_ptr_r];
         hwrite_r <= 1'b1;
         hsize_r  <= {1'b0, wb_size_r[rd_ptr_r]};
         hprot_r  <= 4'b0011;
      end else if (ld_acc_s) begin
         haddr_r  <= req_addr;
         hwrite_r <= 1'b0;
         hsize_r  <= {1'b0, req_size};
         hprot_r  <= {3'b001, !req_ifetch};
      end else if ((state_r == S_WADDR) && HREADY) begin
         hwdata_r <= wb_data_r[rd_ptr_r];
      end
   end

   // Response: one pulse per accepted request, AHB loads when the data phase ends
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_r <= 1'b0;
         rsp_err_r   <= 1'b0;
         rsp_data_r  <= 32'h0000_0000;
         tcm_rd_r    <= 1'b0;
         bank_r      <= {BKW{1'b0}};
         ld_size_r   <= 2'b00;
         ld_lo_r     <= 2'b00;
      end else begin
         rsp_valid_r <= (acc_s && !ld_acc_s) || rd_done_s;
         rsp_err_r   <= acc_s && bad_s;
         tcm_rd_r    <= tcm_acc_s && !req_wr;
         rsp_data_r  <= rd_done_s ? lane_load(ld_size_r, ld_lo_r, HRDATA) : 32'h0000_0000;
         if (acc_s) begin
            bank_r    <= bank_s;
            ld_size_r <= req_size;
            ld_lo_r   <= req_addr[1:0];
         end
      end
   end

   // TCM read data arrives the cycle after select, so it is steered straight through
   assign rsp_data  = tcm_rd_r ? lane_load(ld_size_r, ld_lo_r, tcm_q[bank_r*32 +: 32]) : rsp_data_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_err   = rsp_err_r;

   assign HADDR    = haddr_r;
   assign HTRANS   = htrans_s;
   assign HWRITE   = hwrite_r;
   assign HSIZE    = hsize_r;
   assign HPROT    = hprot_r;
   assign HWDATA   = hwdata_r;
   assign wb_empty = (cnt_r == {CW{1'b0}}) && (state_r != S_WADDR) && (state_r != S_WDATA);

endmodule

// File: tb/tb_ma_wbuf.sv
// Directed bench for ma_wbuf: expected responses are queued at issue time and
// checked by an independent monitor; a small AHB slave model logs bus transfers.
module tb_ma_wbuf;

   localparam int NUM_TCM  = 2;
   localparam int TCM_AW   = 18;
   localparam int WB_DEPTH = 4;

   logic                           clk, rst;
   logic                           req_valid, req_ready, req_wr, req_ifetch;
   logic [1:0]                     req_size;
   logic [31:0]                    req_addr, req_wdata;
   logic [NUM_TCM-1:0]             tcm_en;
   logic [NUM_TCM*(32-TCM_AW)-1:0] tcm_base;
   logic                           rsp_valid, rsp_err;
   logic [31:0]                    rsp_data;
   logic [NUM_TCM-1:0]             tcm_sel;
   logic                           tcm_wr;
   logic [3:0]                     tcm_be;
   logic [TCM_AW-1:0]              tcm_a;
   logic [31:0]                    tcm_d;
   logic [NUM_TCM*32-1:0]          tcm_q;
   logic [31:0]                    HADDR, HWDATA, HRDATA;
   logic [1:0]                     HTRANS;
   logic                           HWRITE, hready_s, wb_empty;
   logic [2:0]                     HSIZE;
   logic [3:0]                     HPROT;

   typedef struct packed {logic err; logic [31:0] data;} exp_t;
   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;

   logic [31:0] wr_addr_log[$];
   logic [31:0] wr_data_log[$];
   logic [31:0] rd_addr_log[$];
   logic [3:0]  rd_prot_log[$];
   logic [2:0]  rd_size_log[$];
   int          rd_wdone_at[$];

   logic               hold_low = 1'b0;
   int                 ws_cfg   = 0;
   int                 ws       = 0;
   logic               dph      = 1'b0;
   logic               dph_wr   = 1'b0;
   logic [NUM_TCM-1:0] acc_sel;
   logic [3:0]         acc_be;
   logic [31:0]        acc_d;
   logic [TCM_AW-1:0]  acc_a;
   logic               acc_wr;
   int                 acc_wdone;

   ma_wbuf #(.NUM_TCM(NUM_TCM), .TCM_AW(TCM_AW), .WB_DEPTH(WB_DEPTH)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_ifetch(req_ifetch), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
      .tcm_en(tcm_en), .tcm_base(tcm_base), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
      .rsp_data(rsp_data), .tcm_sel(tcm_sel), .tcm_wr(tcm_wr), .tcm_be(tcm_be), .tcm_a(tcm_a),
      .tcm_d(tcm_d), .tcm_q(tcm_q), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
      .HSIZE(HSIZE), .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(hready_s),
      .wb_empty(wb_empty)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   // AHB slave: ws_cfg wait states per data phase, hold_low stalls everything
   assign hready_s = !hold_low && !(dph && (ws > 0));

   always @(posedge clk) begin
      if (rst) begin
         dph <= 1'b0;
         ws  <= 0;
      end else if (hready_s) begin
         if (dph && dph_wr) wr_data_log.push_back(HWDATA);
         if (HTRANS == 2'b10) begin
            dph    <= 1'b1;
            dph_wr <= HWRITE;
            ws     <= ws_cfg;
            if (HWRITE) begin
               wr_addr_log.push_back(HADDR);
            end else begin
               rd_addr_log.push_back(HADDR);
               rd_prot_log.push_back(HPROT);
               rd_size_log.push_back(HSIZE);
               rd_wdone_at.push_back(wr_data_log.size());
            end
         end else begin
            dph <= 1'b0;
         end
      end else if (dph && (ws > 0)) begin
         ws <= ws - 1;
      end
   end

   // Response monitor
   always @(negedge clk) begin
      exp_t e;
      if (!rst && rsp_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: actual data=%h err=%b required=no response", rsp_data, rsp_err);
         end else begin
            e = exp_q.pop_front();
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
         end
      end
   end

   task automatic issue(input logic wr, input logic ifetch, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_data);
      int n;
      n = 0;
      req_valid  = 1'b1;
      req_wr     = wr;
      req_ifetch = ifetch;
      req_size   = size;
      req_addr   = addr;
      req_wdata  = wdata;
      #1;
      while (!req_ready && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!req_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: actual=not accepted required=accepted addr=%h", addr);
      end else begin
         exp_q.push_back({exp_err, exp_data});
         acc_sel   = tcm_sel;
         acc_be    = tcm_be;
         acc_d     = tcm_d;
         acc_a     = tcm_a;
         acc_wr    = tcm_wr;
         acc_wdone = wr_data_log.size();
      end
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 300 && !(wb_empty && exp_q.size() == 0); k++) @(negedge clk);
      chk("drain", {31'd0, wb_empty}, 32'd1);
      chk("rsp_q_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int ri;
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_wr     = 1'b0;
      req_ifetch = 1'b0;
      req_size   = 2'd0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      tcm_en     = 2'b11;
      tcm_base   = {14'h0008, 14'h0004};
      tcm_q      = {32'h8001_1234, 32'h1122_3344};
      HRDATA     = 32'd0;
      repeat (3) @(negedge clk);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_htrans", {30'd0, HTRANS}, 32'd0);
      chk("rst_haddr", HADDR, 32'd0);
      chk("rst_hwrite", {31'd0, HWRITE}, 32'd0);
      chk("rst_wb_empty", {31'd0, wb_empty}, 32'd1);
      chk("rst_tcm_sel", {30'd0, tcm_sel}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // byte store to TCM0 at base|2
      issue(1'b1, 1'b0, 2'd0, 32'h0010_0002, 32'h0000_00A5, 1'b0, 32'd0);
      chk("t1_sel", {30'd0, acc_sel}, 32'd1);
      chk("t1_be", {28'd0, acc_be}, 32'h2);
      chk("t1_d", acc_d, 32'hA5A5_A5A5);
      chk("t1_a", {14'd0, acc_a}, 32'h2);
      chk("t1_wr", {31'd0, acc_wr}, 32'd1);

      // TCM1 loads with sign extension
      issue(1'b0, 1'b0, 2'd1, 32'h0020_0000, 32'd0, 1'b0, 32'hFFFF_8001);
      chk("t2_sel", {30'd0, acc_sel}, 32'd2);
      issue(1'b0, 1'b0, 2'd1, 32'h0020_0002, 32'd0, 1'b0, 32'h0000_1234);
      issue(1'b0, 1'b0, 2'd0, 32'h0020_0000, 32'd0, 1'b0, 32'hFFFF_FF80);
      issue(1'b0, 1'b0, 2'd0, 32'h0020_0003, 32'd0, 1'b0, 32'h0000_0034);

      // overlapping bases: bank 0 wins, unless disabled
      tcm_base = {14'h0004, 14'h0004};
      issue(1'b0, 1'b0, 2'd2, 32'h0010_0000, 32'd0, 1'b0, 32'h1122_3344);
      chk("prio_sel0", {30'd0, acc_sel}, 32'd1);
      tcm_en = 2'b10;
      issue(1'b0, 1'b0, 2'd2, 32'h0010_0000, 32'd0, 1'b0, 32'h8001_1234);
      chk("prio_sel1", {30'd0, acc_sel}, 32'd2);
      tcm_en   = 2'b11;
      tcm_base = {14'h0008, 14'h0004};

      // five AHB stores with the bus stalled: only four fit
      hold_low = 1'b1;
      for (int i = 0; i < 4; i++)
         issue(1'b1, 1'b0, 2'd2, 32'h100 + 32'(4*i), 32'hD000_0000 + 32'(i), 1'b0, 32'd0);
      req_valid = 1'b1;
      req_wr    = 1'b1;
      req_size  = 2'd2;
      req_addr  = 32'h110;
      req_wdata = 32'hD000_0004;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t3_full_ready", {31'd0, req_ready}, 32'd0);
         @(negedge clk);
      end
      chk("t3_haddr_held", HADDR, 32'h100);
      chk("t3_htrans_held", {30'd0, HTRANS}, 32'h2);
      hold_low = 1'b0;
      issue(1'b1, 1'b0, 2'd2, 32'h110, 32'hD000_0004, 1'b0, 32'd0);
      chk("t3_fifth_after_wdata", 32'(acc_wdone), 32'd1);
      wait_drain();
      chk("t3_wr_count", 32'(wr_data_log.size()), 32'd5);
      for (int i = 0; i < 5; i++) begin
         chk("t3_wr_addr", wr_addr_log[i], 32'h100 + 32'(4*i));
         chk("t3_wr_data", wr_data_log[i], 32'hD000_0000 + 32'(i));
      end

      // store then load to the same address, two wait states
      ws_cfg = 2;
      HRDATA = 32'h1234_5678;
      issue(1'b1, 1'b0, 2'd2, 32'h1000, 32'hCAFE_BABE, 1'b0, 32'd0);
      issue(1'b0, 1'b0, 2'd2, 32'h1000, 32'd0, 1'b0, 32'h1234_5678);
      wait_drain();
      chk("t4_rd_count", 32'(rd_addr_log.size()), 32'd1);
      chk("t4_rd_addr", rd_addr_log[0], 32'h1000);
      chk("t4_wr_before_rd", 32'(rd_wdone_at[0]), 32'd6);
      chk("t4_wr_data", wr_data_log[5], 32'hCAFE_BABE);
      chk("t4_hprot", {28'd0, rd_prot_log[0]}, 32'h3);
      chk("t4_hsize", {29'd0, rd_size_log[0]}, 32'h2);

      // byte ifetch from AHB and a byte store with lane replication
      ws_cfg = 0;
      HRDATA = 32'h00F0_0000;
      issue(1'b0, 1'b1, 2'd0, 32'h3001, 32'd0, 1'b0, 32'hFFFF_FFF0);
      issue(1'b1, 1'b0, 2'd0, 32'h5003, 32'h0000_0077, 1'b0, 32'd0);
      wait_drain();
      chk("ifetch_hprot", {28'd0, rd_prot_log[1]}, 32'h2);
      chk("ifetch_hsize", {29'd0, rd_size_log[1]}, 32'h0);
      chk("stb_hwdata", wr_data_log[6], 32'h7777_7777);

      // illegal accesses: error response, no TCM or AHB activity
      ri = rd_addr_log.size();
      issue(1'b0, 1'b0, 2'd2, 32'h0000_0002, 32'd0, 1'b1, 32'd0);
      chk("t5_no_sel", {30'd0, acc_sel}, 32'd0);
      chk("t5_htrans", {30'd0, HTRANS}, 32'd0);
      issue(1'b1, 1'b0, 2'd1, 32'h0010_0001, 32'h1234, 1'b1, 32'd0);
      chk("mis_word_no_sel", {30'd0, acc_sel}, 32'd0);
      issue(1'b0, 1'b0, 2'd3, 32'h0010_0000, 32'd0, 1'b1, 32'd0);
      chk("size3_no_sel", {30'd0, acc_sel}, 32'd0);
      wait_drain();
      chk("t5_no_ahb_read", 32'(rd_addr_log.size()), 32'(ri));
      chk("t5_htrans_idle", {30'd0, HTRANS}, 32'd0);

      // reset during the read data phase
      ws_cfg = 6;
      ri = rd_addr_log.size();
      issue(1'b0, 1'b0, 2'd2, 32'h4000, 32'd0, 1'b0, 32'd0);
      for (int k = 0; k < 20 && rd_addr_log.size() == ri; k++) @(negedge clk);
      chk("t6_in_rdata", 32'(rd_addr_log.size()), 32'(ri + 1));
      rst = 1'b1;
      @(negedge clk);
      chk("t6_htrans", {30'd0, HTRANS}, 32'd0);
      chk("t6_wb_empty", {31'd0, wb_empty}, 32'd1);
      chk("t6_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      exp_q.delete();
      rst    = 1'b0;
      ws_cfg = 0;
      @(negedge clk);

      // traffic resumes after reset
      HRDATA = 32'h0000_7FFF;
      issue(1'b0, 1'b0, 2'd1, 32'h6002, 32'd0, 1'b0, 32'h0000_7FFF);
      wait_drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
